// File: rtl/lc3b_types.sv
// Shared lc3b predictor types and constants (default geometry 3/4/7).
package lc3b_types;

  localparam int unsigned LC3B_BHT_IDX_BITS = 3;
  localparam int unsigned LC3B_HIST_BITS    = 4;
  localparam int unsigned LC3B_PHT_IDX_BITS = LC3B_BHT_IDX_BITS + LC3B_HIST_BITS;
  localparam int unsigned LC3B_CTR_BITS     = 2;

  typedef logic [LC3B_BHT_IDX_BITS-1:0] lc3b_bht_ind;
  typedef logic [LC3B_HIST_BITS-1:0]    lc3b_bht_out;
  typedef logic [LC3B_PHT_IDX_BITS-1:0] lc3b_pht_ind;

  // Weakly-not-taken counter value for a 2-bit counter.
  localparam logic [LC3B_CTR_BITS-1:0] LC3B_CTR_WEAK_NT = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  // Weakly-not-taken value for any counter width: 2^(ctr_bits-1) - 1.
  function automatic int unsigned weak_nt_val(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bpred_two_level_if.sv
// Predict and resolve/update ports of the two-level branch predictor.
interface bpred_two_level_if #(
  parameter int unsigned HIST_BITS = 4
) ();

  logic                 ready;
  logic                 pred_req;
  logic [15:0]          pred_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 upd_valid;
  logic [15:0]          upd_pc;
  logic [HIST_BITS-1:0] upd_hist;
  logic                 upd_taken;

  // Fetch/resolve side driving the predictor.
  modport master (
    input  ready, pred_valid, pred_taken, pred_hist,
    output pred_req, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken
  );

  // Predictor side.
  modport slave (
    output ready, pred_valid, pred_taken, pred_hist,
    input  pred_req, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken
  );

endinterface

// File: rtl/bpred_two_level_sat_counter_update.sv
// Next value of a CTR_BITS saturating counter (inc when taken, else dec).
module sat_counter_update #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_next_c
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  // Saturate at both ends instead of wrapping.
  always_comb begin
    ctr_next_c = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next_c = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != CTR_MIN) ctr_next_c = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/bpred_two_level.sv
// Two-level adaptive branch predictor: BHT of per-branch histories feeding
// a PHT of saturating counters, with a reset-time table init sweep.
// Build option BPRED_GLOBAL_HIST_EN: one global history register replaces the BHT.
module bpred_two_level
  import lc3b_types::*;
#(
  parameter int unsigned BHT_IDX_BITS = 3,
  parameter int unsigned HIST_BITS    = 4,
  parameter int unsigned CTR_BITS     = 2
) (
  input logic               clk,
  input logic               rst_n,
  bpred_two_level_if.slave  bus
);

  localparam int unsigned BHT_ENTRIES  = 1 << BHT_IDX_BITS;
  localparam int unsigned PHT_IDX_BITS = BHT_IDX_BITS + HIST_BITS;
  localparam int unsigned PHT_ENTRIES  = 1 << PHT_IDX_BITS;
  localparam logic [PHT_IDX_BITS-1:0] IDX_LAST = PHT_IDX_BITS'(PHT_ENTRIES - 1);
  localparam logic [CTR_BITS-1:0]     CTR_INIT = CTR_BITS'(weak_nt_val(CTR_BITS));

  bpred_state_e              state_q;
  logic [PHT_IDX_BITS-1:0]   idx_q;
  logic                      ready_q;
  logic                      pred_valid_q;
  logic                      pred_taken_q;
  logic [HIST_BITS-1:0]      pred_hist_q;

  logic [CTR_BITS-1:0]       pht [PHT_ENTRIES];

  logic [BHT_IDX_BITS-1:0]   bidx;
  logic [BHT_IDX_BITS-1:0]   ubidx;
  logic [HIST_BITS-1:0]      pred_h;
  logic [PHT_IDX_BITS-1:0]   pidx;
  logic [PHT_IDX_BITS-1:0]   uidx;
  logic                      in_init;
  logic                      pred_en;
  logic                      upd_en;
  logic [CTR_BITS-1:0]       upd_ctr;
  logic [CTR_BITS-1:0]       upd_ctr_next_c;
  logic                      unused_pc_bits;

  assign bidx    = bus.pred_pc[BHT_IDX_BITS:1];
  assign ubidx   = bus.upd_pc[BHT_IDX_BITS:1];
  assign in_init = (state_q == ST_INIT);
  assign pred_en = (state_q == ST_RUN) && bus.pred_req;
  assign upd_en  = (state_q == ST_RUN) && bus.upd_valid;
  assign pidx    = {bidx, pred_h};
  assign uidx    = {ubidx, bus.upd_hist};
  assign upd_ctr = pht[uidx];

  // Upper PC bits and the byte bit never reach the tables.
  assign unused_pc_bits = ^{bus.pred_pc[15:BHT_IDX_BITS+1], bus.pred_pc[0],
                            bus.upd_pc[15:BHT_IDX_BITS+1], bus.upd_pc[0]};

`ifdef BPRED_GLOBAL_HIST_EN
  logic [HIST_BITS-1:0] ghr_q;

  assign pred_h = ghr_q;

  // Global history shifts in every resolved outcome; held at 0 through init.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= {ghr_q[HIST_BITS-2:0], bus.upd_taken};
    end
  end
`else
  logic [HIST_BITS-1:0] bht [BHT_ENTRIES];

  assign pred_h = bht[bidx];

  // BHT: cleared by the init sweep, then shifts in each resolved outcome.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_init) begin
        bht[idx_q[BHT_IDX_BITS-1:0]] <= '0;
      end else if (upd_en) begin
        bht[ubidx] <= {bht[ubidx][HIST_BITS-2:0], bus.upd_taken};
      end
    end
  end
`endif

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat (
    .ctr        (upd_ctr),
    .inc        (bus.upd_taken),
    .ctr_next_c (upd_ctr_next_c)
  );

  // PHT: weakly-not-taken fill during init, saturating update in run.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_init) begin
        pht[idx_q] <= CTR_INIT;
      end else if (upd_en) begin
        pht[uidx] <= upd_ctr_next_c;
      end
    end
  end

  // Init sweep / run control and registered prediction outputs.
  // Table reads use pre-edge contents, so a same-cycle update is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          pred_valid_q <= 1'b0;
          idx_q        <= idx_q + PHT_IDX_BITS'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          pred_valid_q <= pred_en;
          if (pred_en) begin
            pred_taken_q <= pht[pidx][CTR_BITS-1];
            pred_hist_q  <= pred_h;
          end
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_hist  = pred_hist_q;

endmodule

// File: tb/tb_bpred_two_level.sv
// Directed bench for bpred_two_level (default geometry 3/4/2).
module tb_bpred_two_level;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bpred_two_level_if #(.HIST_BITS(4)) bus ();

  bpred_two_level #(
    .BHT_IDX_BITS (3),
    .HIST_BITS    (4),
    .CTR_BITS     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pred_req  = 1'b0;
    bus.pred_pc   = 16'h0000;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = 16'h0000;
    bus.upd_hist  = 4'h0;
    bus.upd_taken = 1'b0;
  endtask

  task automatic do_update(input logic [15:0] pc, input logic [3:0] h, input logic t);
    bus.upd_valid = 1'b1;
    bus.upd_pc    = pc;
    bus.upd_hist  = h;
    bus.upd_taken = t;
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic do_predict(input logic [15:0] pc, output logic v, output logic t,
                            output logic [3:0] h);
    bus.pred_req = 1'b1;
    bus.pred_pc  = pc;
    tick();
    bus.pred_req = 1'b0;
    v = bus.pred_valid;
    t = bus.pred_taken;
    h = bus.pred_hist;
  endtask

  // Force the history seen by pc to h using updates aimed at a scratch PHT entry.
  task automatic set_hist(input logic [15:0] pc, input logic [3:0] h);
    logic [3:0] scratch;
    scratch = ~h;
    for (int i = 3; i >= 0; i--) do_update(pc, scratch, h[i]);
  endtask

  task automatic observe(input logic [15:0] pc, input logic [3:0] h, output logic v,
                         output logic t, output logic [3:0] hist);
    set_hist(pc, h);
    do_predict(pc, v, t, hist);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    vectors++;
    if ({bus.ready, bus.pred_valid, bus.pred_taken, bus.pred_hist} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b v=%b t=%b h=%b, want all 0",
               bus.ready, bus.pred_valid, bus.pred_taken, bus.pred_hist);
    end
    rst_n = 1'b1;
    wait_ready(cyc);
    vectors++;
    if (cyc != 128) begin
      miscompares++;
      $display("FAIL init_sweep_len: got %0d cycles, want 128", cyc);
    end
  endtask

  task automatic test_first_predict();
    logic v, t;
    logic [3:0] h;
    do_predict(16'h1234, v, t, h);
    vectors++;
    if ({v, t, h} !== {1'b1, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL first_predict: got v=%b t=%b h=%b, want v=1 t=0 h=0000", v, t, h);
    end
    tick();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_hist} !== 6'b0) begin
      miscompares++;
      $display("FAIL idle_after_predict: got v=%b t=%b h=%b, want 0/0/0000",
               bus.pred_valid, bus.pred_taken, bus.pred_hist);
    end
  endtask

  task automatic test_history();
    logic v, t;
    logic [3:0] h;
    do_update(16'h0006, 4'h0, 1'b1);
    do_update(16'h0006, 4'h0, 1'b0);
    do_update(16'h0006, 4'h0, 1'b1);
    do_update(16'h0006, 4'h0, 1'b1);
    do_predict(16'h0006, v, t, h);
    vectors++;
    if ({v, t, h} !== {1'b1, 1'b0, 4'b1011}) begin
      miscompares++;
      $display("FAIL hist_1011: got v=%b t=%b h=%b, want v=1 t=0 h=1011", v, t, h);
    end
    do_update(16'h0006, 4'h0, 1'b0);
    do_predict(16'h0006, v, t, h);
    vectors++;
    if (h !== 4'b0110) begin
      miscompares++;
      $display("FAIL hist_0110: got h=%b, want 0110", h);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pcs [3];
    logic [3:0]  exp_h [3];
    pcs[0] = 16'h0006; pcs[1] = 16'h0004; pcs[2] = 16'h0006;
`ifdef BPRED_GLOBAL_HIST_EN
    exp_h[0] = 4'b0110; exp_h[1] = 4'b0110; exp_h[2] = 4'b0110;
`else
    exp_h[0] = 4'b0110; exp_h[1] = 4'b0000; exp_h[2] = 4'b0110;
`endif
    bus.pred_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pred_pc = pcs[i];
      tick();
      vectors++;
      if ({bus.pred_valid, bus.pred_taken, bus.pred_hist} !== {1'b1, 1'b0, exp_h[i]}) begin
        miscompares++;
        $display("FAIL b2b_%0d: got v=%b t=%b h=%b, want v=1 t=0 h=%b", i,
                 bus.pred_valid, bus.pred_taken, bus.pred_hist, exp_h[i]);
      end
    end
    bus.pred_req = 1'b0;
    tick();
    vectors++;
    if ({bus.pred_valid, bus.pred_hist} !== {1'b0, 4'b0110}) begin
      miscompares++;
      $display("FAIL b2b_hold: got v=%b h=%b, want v=0 h=0110", bus.pred_valid, bus.pred_hist);
    end
  endtask

  task automatic test_saturation();
    logic seq_t   [12];
    logic exp_msb [12];
    logic v, t;
    logic [3:0] h;
    // 01 -> T x5 -> 11 held; N x5 -> 00 held; T x2 -> 10
    seq_t   = '{1,1,1,1,1, 0,0,0,0,0, 1,1};
    exp_msb = '{1,1,1,1,1, 1,0,0,0,0, 0,1};
    for (int i = 0; i < 12; i++) begin
      do_update(16'h0004, 4'h0, seq_t[i]);
      observe(16'h0004, 4'h0, v, t, h);
      vectors++;
      if ({v, t, h} !== {1'b1, exp_msb[i], 4'h0}) begin
        miscompares++;
        $display("FAIL sat_step_%0d: got v=%b t=%b h=%b, want v=1 t=%b h=0000",
                 i, v, t, h, exp_msb[i]);
      end
    end
  endtask

  task automatic test_hazard();
    logic v, t;
    logic [3:0] h;
    set_hist(16'h0008, 4'b1111);
    bus.pred_req  = 1'b1;
    bus.pred_pc   = 16'h0008;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 16'h0008;
    bus.upd_hist  = 4'b1111;
    bus.upd_taken = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    bus.pred_req  = 1'b0;
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_hist} !== {1'b1, 1'b0, 4'b1111}) begin
      miscompares++;
      $display("FAIL hazard_same_cycle: got v=%b t=%b h=%b, want v=1 t=0 h=1111",
               bus.pred_valid, bus.pred_taken, bus.pred_hist);
    end
    do_predict(16'h0008, v, t, h);
    vectors++;
    if ({v, t, h} !== {1'b1, 1'b1, 4'b1111}) begin
      miscompares++;
      $display("FAIL hazard_next_cycle: got v=%b t=%b h=%b, want v=1 t=1 h=1111", v, t, h);
    end
  endtask

  task automatic test_loop();
    logic v, t, outcome;
    logic [3:0] h;
    int win_mis;
    for (int it = 0; it < 64; it++) begin
      if (it % 4 == 0) win_mis = 0;
      for (int k = 0; k < 4; k++) begin
        outcome = (k != 3);
        do_predict(16'h0010, v, t, h);
        if (v !== 1'b1 || t !== outcome) win_mis++;
        do_update(16'h0010, h, outcome);
      end
      if (it % 4 == 3 && it >= 15) begin
        vectors++;
        if (win_mis != 0) begin
          miscompares++;
          $display("FAIL loop_window_%0d: got %0d mispredicts, want 0", it / 4, win_mis);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic v, t;
    logic [3:0] h;
    int cyc;
    do_update(16'h000A, 4'h0, 1'b1);
    do_update(16'h000A, 4'h0, 1'b1);
    do_update(16'h000A, 4'h0, 1'b1);
    observe(16'h000A, 4'h0, v, t, h);
    vectors++;
    if (t !== 1'b1) begin
      miscompares++;
      $display("FAIL trained_before_reset: got t=%b, want 1", t);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_mid_sweep: got %b, want 0", bus.ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(cyc);
    vectors++;
    if (cyc != 128) begin
      miscompares++;
      $display("FAIL restart_sweep_len: got %0d cycles, want 128", cyc);
    end
    do_predict(16'h0006, v, t, h);
    vectors++;
    if ({v, h} !== {1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL hist_cleared: got v=%b h=%b, want v=1 h=0000", v, h);
    end
    observe(16'h000A, 4'h0, v, t, h);
    vectors++;
    if (t !== 1'b0) begin
      miscompares++;
      $display("FAIL pht_reinit: got t=%b, want 0", t);
    end
    do_update(16'h000A, 4'h0, 1'b1);
    observe(16'h000A, 4'h0, v, t, h);
    vectors++;
    if (t !== 1'b1) begin
      miscompares++;
      $display("FAIL pht_reinit_weak: got t=%b, want 1", t);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_first_predict();
    test_history();
    test_back_to_back();
    test_saturation();
    test_hazard();
    test_loop();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
